// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: register address width and the RV32M multiply/divide
// operation and state encodings used by the execute-stage muldiv unit.
package riscv_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;

    // RV32M funct3 encoding
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div_op(input muldiv_op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage: one operation in flight,
// shift-add multiply and restoring divide on magnitudes, result returned with its tag.
module ex_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned TAG_WIDTH      = REG_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      result,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 busy
);

    localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N) + 1;

    muldiv_state_e          state_q, state_d;
    muldiv_op_e             op_in, op_q;
    logic                   neg_q, rem_neg_q;
    logic [XLEN-1:0]        opnd_q;
    logic [2*XLEN-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [XLEN-1:0]        result_q;
    logic [TAG_WIDTH-1:0]   tag_q;

    logic                   accept, last_iter;
    logic                   signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0]        a_mag, b_mag;
    logic                   div_by_zero, overflow, special;
    logic [XLEN-1:0]        special_res;
    logic [XLEN:0]          hi, diff, sum;
    logic [2*XLEN-1:0]      prod;
    logic [XLEN-1:0]        quo, rem, fin_res;

    assign op_in     = muldiv_op_e'(op);
    assign in_ready  = (state_q == IDLE) && !reset;
    assign accept    = in_valid && in_ready && !flush;
    assign last_iter = (cnt_q == CNT_W'(N - 1));
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign tag_out   = tag_q;

    // Operand decode at the accept edge: signedness, magnitudes and special cases
    always_comb begin
        signed_a    = op_in inside {MULH, MULHSU, DIV, REM};
        signed_b    = op_in inside {MULH, DIV, REM};
        a_neg       = signed_a && a[XLEN-1];
        b_neg       = signed_b && b[XLEN-1];
        a_mag       = a_neg ? (~a + XLEN'(1)) : a;
        b_mag       = b_neg ? (~b + XLEN'(1)) : b;
        div_by_zero = (b == '0);
        overflow    = (op_in inside {DIV, REM}) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special     = is_div_op(op_in) && (div_by_zero || overflow);
        special_res = '0;
        if (div_by_zero) begin
            special_res = (op_in inside {DIV, DIVU}) ? '1 : a;
        end else if (overflow) begin
            special_res = (op_in == DIV) ? a : '0;
        end
    end

    // BITS_PER_CYCLE unrolled steps; mul and div share acc_q/opnd_q
    always_comb begin
        acc_d = acc_q;
        hi    = '0;
        diff  = '0;
        sum   = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div_op(op_q)) begin
                hi   = {acc_d[2*XLEN-1:XLEN], acc_d[XLEN-1]};
                diff = hi - {1'b0, opnd_q};
                if (!diff[XLEN]) begin
                    acc_d = {diff[XLEN-1:0], acc_d[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {hi[XLEN-1:0], acc_d[XLEN-2:0], 1'b0};
                end
            end else begin
                sum   = {1'b0, acc_d[2*XLEN-1:XLEN]} + (acc_d[0] ? {1'b0, opnd_q} : '0);
                acc_d = {sum, acc_d[XLEN-1:1]};
            end
        end
    end

    // Sign fix-up applied to the final step's value
    always_comb begin
        prod = neg_q ? (~acc_d + (2*XLEN)'(1)) : acc_d;
        quo  = neg_q ? (~acc_d[XLEN-1:0] + XLEN'(1)) : acc_d[XLEN-1:0];
        rem  = rem_neg_q ? (~acc_d[2*XLEN-1:XLEN] + XLEN'(1)) : acc_d[2*XLEN-1:XLEN];
        case (op_q)
            MUL:                 fin_res = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: fin_res = prod[2*XLEN-1:XLEN];
            DIV, DIVU:           fin_res = quo;
            default:             fin_res = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= MUL;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            tag_q     <= '0;
        end else if (accept) begin
            op_q      <= op_in;
            tag_q     <= tag_in;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            cnt_q     <= '0;
            if (is_div_op(op_in)) begin
                opnd_q <= b_mag;
                acc_q  <= {{XLEN{1'b0}}, a_mag};
            end else begin
                opnd_q <= a_mag;
                acc_q  <= {{XLEN{1'b0}}, b_mag};
            end
            if (special) begin
                result_q <= special_res;
            end
        end else if (state_q == CALC && !flush) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_iter) begin
                result_q <= fin_res;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: a radix-2 (BPC=1) and a radix-16 (BPC=4) instance
// share all inputs; per-instance monitors check result, tag, latency and output stability.
module tb_ex_muldiv_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, flush, in_valid, out_ready;
    logic [2:0]        op;
    logic [31:0]       a, b;
    logic [4:0]        tag_in;
    logic [1:0]        in_ready, out_valid, busy;
    logic [1:0][31:0]  result;
    logic [1:0][4:0]   tag_out;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
        .op(op), .a(a), .b(b), .tag_in(tag_in), .out_valid(out_valid[0]), .out_ready(out_ready),
        .result(result[0]), .tag_out(tag_out[0]), .busy(busy[0])
    );

    ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_WIDTH(5)) dut4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
        .op(op), .a(a), .b(b), .tag_in(tag_in), .out_valid(out_valid[1]), .out_ready(out_ready),
        .result(result[1]), .tag_out(tag_out[1]), .busy(busy[1])
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        bit          special;
        string       name;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        bit          special;
        string       name;
    } vec_t;

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h, required %h", name, g, act, req);
        end
    endtask

    task automatic monitor(input int g);
        bit          in_flight = 1'b0;
        bit          ir_high = 1'b0;
        bit          unstable = 1'b0;
        int          acc_cyc = 0;
        int          first = -1;
        int          lat_exp;
        logic [31:0] hold_res;
        logic [4:0]  hold_tag;
        exp_t        e;
        hold_res = '0;
        hold_tag = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset || flush) begin
                in_flight = 1'b0;
                first = -1;
            end else begin
                if (in_flight && in_ready[g]) ir_high = 1'b1;
                if (out_valid[g]) begin
                    if (first < 0) begin
                        first = cyc;
                        hold_res = result[g];
                        hold_tag = tag_out[g];
                    end else if (result[g] !== hold_res || tag_out[g] !== hold_tag) begin
                        unstable = 1'b1;
                    end
                    if (out_ready) begin
                        if ((g == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_output dut%0d: got result %h tag %0d, required no output",
                                     g, result[g], tag_out[g]);
                        end else begin
                            e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            lat_exp = e.special ? 0 : (g == 0 ? 32 : 8);
                            check({e.name, "_result"}, g, result[g], e.res);
                            check({e.name, "_tag"}, g, 32'(tag_out[g]), 32'(e.tag));
                            check({e.name, "_edges_after_accept"}, g, 32'(first - acc_cyc), 32'(lat_exp));
                            check({e.name, "_in_ready_high_while_busy"}, g, 32'(ir_high), 32'd0);
                            check({e.name, "_output_unstable"}, g, 32'(unstable), 32'd0);
                        end
                        in_flight = 1'b0;
                        first = -1;
                    end
                end
                if (in_valid && in_ready[g]) begin
                    in_flight = 1'b1;
                    acc_cyc = cyc + 1;
                    ir_high = 1'b0;
                    unstable = 1'b0;
                    first = -1;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic issue(input vec_t v);
        exp_t e;
        for (int n = 0; n < 500 && in_ready != 2'b11; n++) @(negedge clk);
        if (in_ready != 2'b11) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_issue_timeout: in_ready %b, required 11", v.name, in_ready);
            return;
        end
        op = v.op;
        a = v.a;
        b = v.b;
        tag_in = v.tag;
        in_valid = 1'b1;
        e.res = v.res;
        e.tag = v.tag;
        e.special = v.special;
        e.name = v.name;
        exp_q0.push_back(e);
        exp_q1.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = '1;
        b = '1;
        op = 3'd7;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 300 && (exp_q0.size() != 0 || exp_q1.size() != 0); n++) @(negedge clk);
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_drain_timeout: %0d/%0d results outstanding, required 0",
                     name, exp_q0.size(), exp_q1.size());
            exp_q0.delete();
            exp_q1.delete();
        end
        @(negedge clk);
    endtask

    vec_t vecs[12];
    vec_t v;

    initial begin
        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0, "mul_7_m3"};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 1'b0, "mulh_min_min"};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1'b0, "mulhu_ones"};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 1'b0, "mulhsu_ones"};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 1'b0, "div_m7_2"};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 1'b0, "rem_m7_2"};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        1'b0, "divu_100_7"};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         1'b0, "remu_100_7"};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         5'd20, 32'hFFFF_FFFF, 1'b1, "divu_by_zero"};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         5'd21, 32'd5,         1'b1, "rem_by_zero"};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 1'b1, "div_overflow"};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'd0,         1'b1, "rem_overflow"};
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = '0;
        a = '0;
        b = '0;
        tag_in = '0;
        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (2) @(negedge clk);
        check("in_ready_during_reset", 0, 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 0, 32'(in_ready), 32'h3);
        check("reset_out_valid", 0, 32'(out_valid), 32'd0);
        check("reset_busy", 0, 32'(busy), 32'd0);
        for (int g = 0; g < 2; g++) begin
            check("reset_result", g, result[g], 32'd0);
            check("reset_tag_out", g, 32'(tag_out[g]), 32'd0);
        end

        foreach (vecs[i]) issue(vecs[i]);
        drain("directed");

        // Backpressure: hold the result in DONE, then release into a back-to-back op
        out_ready = 1'b0;
        v = '{3'd3, 32'h1234_5678, 32'h0000_0010, 5'd9, 32'h0000_0001, 1'b0, "bp_mulhu"};
        issue(v);
        for (int n = 0; n < 100 && out_valid != 2'b11; n++) @(negedge clk);
        check("bp_out_valid", 0, 32'(out_valid), 32'h3);
        repeat (5) @(negedge clk);
        check("bp_in_ready_stalled", 0, 32'(in_ready), 32'd0);
        check("bp_out_valid_held", 0, 32'(out_valid), 32'h3);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_after_handshake", 0, 32'(in_ready), 32'h3);
        v = '{3'd5, 32'd1000, 32'd10, 5'd10, 32'd100, 1'b0, "b2b_divu"};
        issue(v);
        drain("backpressure");

        // Flush around iteration 10 of the radix-2 divide; radix-16 copy has already returned
        v = '{3'd4, 32'd1000, 32'd3, 5'd11, 32'd333, 1'b0, "flushed_div"};
        issue(v);
        repeat (9) @(negedge clk);
        exp_q0.delete();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 0, 32'(in_ready), 32'h3);
        check("flush_out_valid", 0, 32'(out_valid), 32'd0);
        repeat (40) @(negedge clk);
        v = '{3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 1'b0, "mul_after_flush"};
        issue(v);
        drain("flush");

        // Reset in the middle of an operation
        v = '{3'd0, 32'd3, 32'd4, 5'd13, 32'd12, 1'b0, "reset_killed_mul"};
        issue(v);
        repeat (4) @(negedge clk);
        exp_q0.delete();
        exp_q1.delete();
        reset = 1'b1;
        @(negedge clk);
        check("midreset_in_ready", 0, 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 0, 32'(out_valid), 32'd0);
        check("midreset_busy", 0, 32'(busy), 32'd0);
        check("midreset_in_ready_after", 0, 32'(in_ready), 32'h3);
        for (int g = 0; g < 2; g++) begin
            check("midreset_result", g, result[g], 32'd0);
            check("midreset_tag_out", g, 32'(tag_out[g]), 32'd0);
        end
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
